fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Parametrised instruction-fetch front end for the pipelined successor of the single-cycle RISC-V core.
- Owns the PC register, a trigger-started run/idle FSM, instruction-memory addressing and the IF/ID pipeline register.
- Supports stall, flush-on-redirect and a saturating fetch counter.
- Downstream decode/execute stages consume the IF/ID outputs and drive redirects back.

Parameters:
XLEN, 32, datapath/PC width in bits (>= 16)
RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)
CNT_W, 16, width of the saturating fetch counter
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID when empty or flushed (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
trigger  in  1  start request; sampled only in IDLE
stall  in  1  hold PC and IF/ID this cycle
redirect  in  1  branch/jump resolved downstream; load redirect_pc and flush
redirect_pc  in  XLEN  redirect target
imem_addr  out  XLEN  instruction memory address (= PC, combinational)
imem_rdata  in  32  instruction word at imem_addr, asynchronous read
if_id_instr  out  32  registered instruction
if_id_pc  out  XLEN  registered PC of if_id_instr
if_id_pc4  out  XLEN  registered if_id_pc + 4
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pred_taken  out  1  fetch predicted this instruction taken
running  out  1  FSM in RUN
fetch_count  out  CNT_W  number of instructions captured into IF/ID, saturating

Behaviour:
- Reset (rst=1 at rising edge): PC=RESET_PC, FSM=IDLE, if_id_instr=NOP_INSTR, if_id_pc=RESET_PC, if_id_pc4=RESET_PC+4, if_id_valid=0, if_id_pred_taken=0, running=0, fetch_count=0. Reset overrides every other input, including mid-run.
- FSM states: IDLE, RUN. running=1 only in RUN.
  - IDLE: PC holds; IF/ID holds NOP with valid=0; stall and redirect are ignored. trigger=1 moves the FSM to RUN at the next edge. The first fetch captures on the edge after entry to RUN.
  - RUN: trigger is ignored. Only rst returns the FSM to IDLE.
- RUN cycle priority, highest first:
  - redirect=1: PC<=redirect_pc with bits [1:0] forced to 0; IF/ID<=NOP, valid=0, pred_taken=0; counter unchanged. This applies even if stall=1.
  - stall=1: PC, IF/ID and counter all hold.
  - Otherwise:
    - IF/ID<=imem_rdata, PC, PC+4, valid=1.
    - PC<=next_pc.
    - fetch_count increments, saturating at 2^CNT_W-1.
- next_pc = PC+4 unless the optional prediction applies. All PC arithmetic is modulo 2^XLEN, so PC 0xFFFF_FFFC advances to 0x0000_0000 when XLEN=32.
- Latency: an instruction at address A appears on if_id_* one edge after PC=A in an unstalled, unredirected cycle.
- imem_addr is combinational from the PC register. There is no combinational path from imem_rdata to any output.

Optional Feature:
Macro FETCH_BTFN_PREDICT_EN.
- Defined: static prediction, applied to the fetched word before the edge.
  - Opcode 7'b1100011 with instr[31]=1 (backward branch): next_pc = PC + sign-extended B-immediate, pred_taken=1.
  - Opcode 7'b1101111 (JAL): next_pc = PC + sign-extended J-immediate, pred_taken=1.
  - All other words: PC+4, pred_taken=0.
  - A redirect in the same cycle still wins.
- Undefined: next_pc is always PC+4 and if_id_pred_taken is constant 0. The immediate decode logic is not synthesised.

Test Plan:
1. Reset, then trigger low for 5 cycles -> running=0, imem_addr=0, if_id_valid=0, if_id_instr=0x00000013, fetch_count=0.
2. trigger pulse, memory holds 0x00500093 at 0 and 0x00100113 at 4 -> edge 2 after trigger gives if_id_pc=0, if_id_instr=0x00500093, valid=1; next edge gives if_id_pc=4, fetch_count=2.
3. stall held 3 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged, fetch_count unchanged; release resumes fetch at 8.
4. redirect=1 with stall=1 and redirect_pc=0x103 -> next edge gives PC=0x100, if_id_valid=0, if_id_instr=NOP, fetch_count unchanged.
5. PC forced via redirect to 0xFFFFFFFC (XLEN=32), then fetch -> if_id_pc4=0, next imem_addr=0. Separately, with CNT_W=2, 5 fetches -> fetch_count=3.
6. FETCH_BTFN_PREDICT_EN defined, word 0xFE000EE3 (beq x0,x0,-4) at 0x20 -> next imem_addr=0x1C and if_id_pred_taken=1. The same word with the macro undefined -> next imem_addr=0x24 and pred_taken=0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch front end for the pipelined RISC-V core. Holds the PC,
//   a trigger-started IDLE/RUN FSM, drives instruction-memory addressing and
//   owns the IF/ID pipeline register plus a saturating fetch counter.
//
//   Optional build macro: FETCH_BTFN_PREDICT_EN
//     defined   -> static backward-taken/forward-not-taken prediction for
//                  conditional branches, and always-taken for JAL
//     undefined -> next PC is always PC+4, if_id_pred_taken tied to 0
//
// Ports
//   clk               system clock, all state on rising edge
//   rst               synchronous active-high reset
//   trigger           start request, sampled only in IDLE
//   stall             hold PC, IF/ID and counter this cycle
//   redirect          downstream branch/jump resolution: load redirect_pc, flush
//   redirect_pc       redirect target (low two bits dropped)
//   imem_addr         instruction memory address (= PC, combinational)
//   imem_rdata        instruction word at imem_addr (asynchronous read)
//   if_id_instr       registered instruction
//   if_id_pc          registered PC of if_id_instr
//   if_id_pc4         registered if_id_pc + 4
//   if_id_valid       IF/ID holds a real instruction
//   if_id_pred_taken  fetch predicted this instruction taken
//   running           FSM is in RUN
//   fetch_count       instructions captured into IF/ID, saturating
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(32'h0000_0000),
  parameter int unsigned      CNT_W     = 16,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic             if_id_valid,
  output logic             if_id_pred_taken,
  output logic             running,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            pred_taken;

  // Per-cycle actions decoded from the FSM and the RUN priority chain.
  logic            do_flush;
  logic            do_capture;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign imem_addr = pc_q;
  assign running   = (state_q == RUN);

  // ---------------------------------------------------------------------------
  // Next sequential PC, optionally steered by static prediction
  // ---------------------------------------------------------------------------
`ifdef FETCH_BTFN_PREDICT_EN
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic            pred_reg;

  assign imm_b = {{(XLEN-13){imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                  imem_rdata[20], imem_rdata[30:21], 1'b0};

  always_comb begin
    next_pc    = pc_plus4;
    pred_taken = 1'b0;
    if (imem_rdata[6:0] == OPC_BRANCH && imem_rdata[31]) begin
      next_pc    = pc_q + imm_b;
      pred_taken = 1'b1;
    end else if (imem_rdata[6:0] == OPC_JAL) begin
      next_pc    = pc_q + imm_j;
      pred_taken = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_reg <= 1'b0;
    end else if (do_flush) begin
      pred_reg <= 1'b0;
    end else if (do_capture) begin
      pred_reg <= pred_taken;
    end
  end

  assign if_id_pred_taken = pred_reg;
`else
  assign next_pc          = pc_plus4;
  assign pred_taken       = 1'b0;
  assign if_id_pred_taken = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and per-cycle action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    do_flush   = 1'b0;
    do_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Redirect outranks stall; stall outranks a normal fetch.
        if (redirect) begin
          do_flush = 1'b1;
        end else if (!stall) begin
          do_capture = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (do_flush) begin
      pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (do_capture) begin
      pc_q <= next_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= RESET_PC;
      if_id_pc4   <= RESET_PC + XLEN'(4);
      if_id_valid <= 1'b0;
    end else if (do_flush) begin
      // Flush only kills the instruction; pc/pc4 are don't-care while invalid.
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (do_capture) begin
      if_id_instr <= imem_rdata;
      if_id_pc    <= pc_q;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating fetch counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (do_capture && (fetch_count != '1)) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst, trigger, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
  logic        if_id_valid, if_id_pred_taken, running;
  logic [15:0] fetch_count;

  // Narrow-counter instance
  logic        rst2, trigger2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic [31:0] if_id_instr2, if_id_pc2, if_id_pc42;
  logic        if_id_valid2, if_id_pred_taken2, running2;
  logic [1:0]  fetch_count2;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] mem [0:127];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a < 32'd512) return mem[a[8:2]];
    return 32'h0000_0013;
  endfunction

  always_comb imem_rdata  = mem_read(imem_addr);
  always_comb imem_rdata2 = mem_read(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst(rst), .trigger(trigger), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .if_id_pred_taken(if_id_pred_taken),
    .running(running), .fetch_count(fetch_count)
  );

  fetch_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .trigger(trigger2), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2), .if_id_pc4(if_id_pc42),
    .if_id_valid(if_id_valid2), .if_id_pred_taken(if_id_pred_taken2),
    .running(running2), .fetch_count(fetch_count2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0050_0093;    // addi x1,x0,5
    mem[1]  = 32'h0010_0113;    // addi x2,x0,1
    mem[2]  = 32'h0020_0193;    // addi x3,x0,2
    mem[3]  = 32'h0030_0213;    // addi x4,x0,3
    mem[8]  = 32'hFE00_0EE3;    // beq x0,x0,-4 at 0x20

    rst = 1'b1; trigger = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst2 = 1'b1; trigger2 = 1'b0;
    #1;
    tick(2);
    rst = 1'b0;

    // Idle with trigger low
    tick(5);
    check("idle_running", running, 0);
    check("idle_addr", imem_addr, 0);
    check("idle_valid", if_id_valid, 0);
    check("idle_instr", if_id_instr, 32'h13);
    check("idle_count", fetch_count, 0);
    check("idle_pc4", if_id_pc4, 4);

    // Stall/redirect ignored in IDLE
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    check("idle_ignore_addr", imem_addr, 0);
    check("idle_ignore_running", running, 0);
    stall = 1'b0; redirect = 1'b0;

    // Trigger pulse
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("run_entry_running", running, 1);
    check("run_entry_valid", if_id_valid, 0);
    tick();
    check("f0_pc", if_id_pc, 0);
    check("f0_instr", if_id_instr, 32'h0050_0093);
    check("f0_valid", if_id_valid, 1);
    check("f0_pc4", if_id_pc4, 4);
    check("f0_addr", imem_addr, 4);
    tick();
    check("f1_pc", if_id_pc, 4);
    check("f1_instr", if_id_instr, 32'h0010_0113);
    check("f1_count", fetch_count, 2);
    check("f1_addr", imem_addr, 8);

    // Stall three cycles at PC=8
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imem_addr, 8);
      check("stall_pc", if_id_pc, 4);
      check("stall_count", fetch_count, 2);
    end
    stall = 1'b0;
    tick();
    check("resume_pc", if_id_pc, 8);
    check("resume_instr", if_id_instr, 32'h0020_0193);
    check("resume_count", fetch_count, 3);

    // Redirect beats stall, low bits dropped
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("redir_addr", imem_addr, 32'h100);
    check("redir_valid", if_id_valid, 0);
    check("redir_instr", if_id_instr, 32'h13);
    check("redir_count", fetch_count, 3);
    check("redir_pred", if_id_pred_taken, 0);

    // Trigger ignored in RUN
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("run_trigger_running", running, 1);
    check("run_fetch_pc", if_id_pc, 32'h100);
    check("run_fetch_count", fetch_count, 4);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_id_pc4, 0);
    check("wrap_addr", imem_addr, 0);
    check("wrap_count", fetch_count, 5);

    // Backward branch at 0x20
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    check("br_pc", if_id_pc, 32'h20);
    check("br_instr", if_id_instr, 32'hFE00_0EE3);
`ifdef FETCH_BTFN_PREDICT_EN
    check("br_addr", imem_addr, 32'h1C);
    check("br_pred", if_id_pred_taken, 1);
`else
    check("br_addr", imem_addr, 32'h24);
    check("br_pred", if_id_pred_taken, 0);
`endif
    check("br_count", fetch_count, 6);

    // Mid-run reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_running", running, 0);
    check("mrst_addr", imem_addr, 0);
    check("mrst_valid", if_id_valid, 0);
    check("mrst_count", fetch_count, 0);
    check("mrst_pred", if_id_pred_taken, 0);

    // Saturating 2-bit counter
    rst2 = 1'b0;
    trigger2 = 1'b1;
    tick();
    trigger2 = 1'b0;
    check("sat_start", fetch_count2, 0);
    tick(3);
    check("sat_three", fetch_count2, 3);
    tick(2);
    check("sat_five", fetch_count2, 3);
    check("sat_pc", if_id_pc2, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
